// File: rtl/reg_bus_initiator_if.sv
// memory_32_32 register bus: initiator drives ADDR/DATA_WR/WSTRB/WE/RE,
// responder returns DATA_RD/READY. outward/inward are the bus-side names for master/slave.
interface memory_32_32 #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] ADDR;
    logic [DATA_W-1:0] DATA_WR;
    logic [DATA_W-1:0] DATA_RD;
    logic [3:0]        WSTRB;
    logic              WE;
    logic              RE;
    logic              READY;

    modport master  (output ADDR, DATA_WR, WSTRB, WE, RE, input DATA_RD, READY);
    modport slave   (input ADDR, DATA_WR, WSTRB, WE, RE, output DATA_RD, READY);
    modport outward (output ADDR, DATA_WR, WSTRB, WE, RE, input DATA_RD, READY);
    modport inward  (input ADDR, DATA_WR, WSTRB, WE, RE, output DATA_RD, READY);
endinterface

// File: rtl/reg_bus_initiator.sv
// Register-bus initiator: one valid/ready command becomes one SETUP/ACCESS bus transaction.
// Define REG_BUS_INITIATOR_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES without READY.
module reg_bus_initiator #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    input  logic [3:0]        cmd_wstrb,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    memory_32_32.outward      bus
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t            state, state_next;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic              we_q, we_d;
    logic              re_q, re_d;
    logic              write_q, write_d;
    logic              rsp_valid_d;
    logic              rsp_err_d;
    logic [DATA_W-1:0] rsp_rdata_d;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("reg_bus_initiator: TIMEOUT_CYCLES must be >= 1");
    end

`ifdef REG_BUS_INITIATOR_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    assign cmd_ready   = (state == IDLE);
    assign bus.ADDR    = addr_q;
    assign bus.DATA_WR = wdata_q;
    assign bus.WSTRB   = wstrb_q;
    assign bus.WE      = we_q;
    assign bus.RE      = re_q;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and next-value logic; every registered output is recomputed here.
    always_comb begin
        state_next  = state;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        we_d        = we_q;
        re_d        = re_q;
        write_d     = write_q;
        rsp_valid_d = rsp_valid;
        rsp_err_d   = rsp_err;
        rsp_rdata_d = rsp_rdata;
`ifdef REG_BUS_INITIATOR_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    if (cmd_addr[1:0] != 2'b00) begin
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                        state_next  = RESP;
                    end else begin
                        addr_d     = cmd_addr;
                        write_d    = cmd_write;
                        wstrb_d    = cmd_write ? cmd_wstrb : 4'h0;
                        if (cmd_write) begin
                            wdata_d = cmd_wdata;
                        end
                        state_next = SETUP;
                    end
                end
            end
            SETUP: begin
                we_d       = write_q;
                re_d       = !write_q;
`ifdef REG_BUS_INITIATOR_TIMEOUT_EN
                cnt_d      = '0;
`endif
                state_next = ACCESS;
            end
            ACCESS: begin
                if (bus.READY) begin
                    we_d        = 1'b0;
                    re_d        = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = write_q ? '0 : bus.DATA_RD;
                    state_next  = RESP;
`ifdef REG_BUS_INITIATOR_TIMEOUT_EN
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    // This edge is the TIMEOUT_CYCLES-th ACCESS edge without READY.
                    cnt_d       = cnt_q + 1'b1;
                    we_d        = 1'b0;
                    re_d        = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                    state_next  = RESP;
                end else begin
                    cnt_d       = cnt_q + 1'b1;
`endif
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_next  = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= 4'h0;
            we_q      <= 1'b0;
            re_q      <= 1'b0;
            write_q   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            we_q      <= we_d;
            re_q      <= re_d;
            write_q   <= write_d;
            rsp_valid <= rsp_valid_d;
            rsp_err   <= rsp_err_d;
            rsp_rdata <= rsp_rdata_d;
        end
    end

`ifdef REG_BUS_INITIATOR_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_reg_bus_initiator.sv
// Bench for reg_bus_initiator: table of directed vectors, randomized transactions against a
// word-memory reference model, throughput, stuck-responder and mid-ACCESS reset sequences.
module tb_reg_bus_initiator;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst_b;
    logic        cmd_valid, cmd_ready, cmd_write, rsp_valid, rsp_ready, rsp_err;
    logic [31:0] cmd_addr, cmd_wdata, rsp_rdata;
    logic [3:0]  cmd_wstrb;

    int n_checks = 0;
    int n_fail   = 0;

    memory_32_32 #(.ADDR_W(32), .DATA_W(32)) bus ();

    reg_bus_initiator #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_b(rst_b),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .bus(bus)
    );

    always #5 clk = ~clk;

    // Responder: 64-word regs/RAM block with programmable wait states or a stuck READY.
    logic [31:0] mem [0:63];
    int          acc_cnt;
    int          resp_wait = 0;
    logic        stuck = 1'b0;

    assign bus.READY   = (bus.WE || bus.RE) && !stuck && (acc_cnt >= resp_wait);
    assign bus.DATA_RD = mem[bus.ADDR[7:2]];

    always @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
            mem[2]  <= 32'h0020_0010;
            mem[8]  <= 32'hCAFE_0020;
            acc_cnt <= 0;
        end else begin
            if (bus.WE || bus.RE) begin
                if (!bus.READY) acc_cnt <= acc_cnt + 1;
            end else begin
                acc_cnt <= 0;
            end
            if (bus.WE && bus.READY) begin
                for (int b = 0; b < 4; b++)
                    if (bus.WSTRB[b]) mem[bus.ADDR[7:2]][8*b +: 8] <= bus.DATA_WR[8*b +: 8];
            end
        end
    end

    // Reference model: plain word array plus the latency rules in cycles after accept.
    logic [31:0] model_mem [0:63];

    task automatic model_init();
        for (int i = 0; i < 64; i++) model_mem[i] = 32'h0;
        model_mem[2] = 32'h0020_0010;
        model_mem[8] = 32'hCAFE_0020;
    endtask

    task automatic model_predict(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                                 input logic [3:0] ws, input int wt,
                                 output logic [31:0] e_rdata, output logic e_err,
                                 output int e_lat, output int e_we, output int e_re);
        int idx;
        idx = int'(a / 4) % 64;
        if (a % 4 != 0) begin
            e_rdata = 32'h0; e_err = 1'b1; e_lat = 1; e_we = 0; e_re = 0;
        end else begin
            e_err = 1'b0;
            e_lat = 3 + wt;
            e_we  = wr ? wt + 1 : 0;
            e_re  = wr ? 0 : wt + 1;
            if (wr) begin
                e_rdata = 32'h0;
                for (int b = 0; b < 4; b++)
                    if (ws[b]) model_mem[idx][8*b +: 8] = wd[8*b +: 8];
            end else begin
                e_rdata = model_mem[idx];
            end
        end
    endtask

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat, we_n, re_n, proto_bad;
        logic        valid_after, ready_after;
    } obs_t;

    typedef struct {
        logic        wr;
        logic [31:0] addr, wdata;
        logic [3:0]  wstrb;
        int          wt, hold;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat, exp_we, exp_re;
    } vec_t;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic start_cmd(input logic wr, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = wd; cmd_wstrb = ws;
        checkOutput("cmd_ready_before_accept", {31'b0, cmd_ready}, 32'd1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic applyStimulus(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                                 input logic [3:0] ws, input int wt, input int hold, output obs_t o);
        o = '{rdata: 32'h0, err: 1'b0, lat: 0, we_n: 0, re_n: 0, proto_bad: 0,
              valid_after: 1'b0, ready_after: 1'b0};
        resp_wait = wt;
        start_cmd(wr, a, wd, ws);
        do begin
            @(negedge clk);
            o.lat++;
            if (bus.WE) o.we_n++;
            if (bus.RE) o.re_n++;
            if (bus.WE && bus.RE) o.proto_bad++;
            if ((bus.WE || bus.RE) && bus.ADDR != a) o.proto_bad++;
            if (bus.WE && (bus.WSTRB != ws || bus.DATA_WR != wd)) o.proto_bad++;
            if (bus.RE && bus.WSTRB != 4'h0) o.proto_bad++;
        end while (!rsp_valid && o.lat < 200);
        o.rdata = rsp_rdata;
        o.err   = rsp_err;
        repeat (hold) begin
            @(negedge clk);
            if (!rsp_valid || rsp_rdata != o.rdata || rsp_err != o.err) o.proto_bad++;
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        o.valid_after = rsp_valid;
        o.ready_after = cmd_ready;
    endtask

    task automatic checkTxn(input string tag, input logic [31:0] e_rdata, input logic e_err,
                            input int e_lat, input int e_we, input int e_re, input obs_t o);
        checkOutput({tag, "_rdata"}, o.rdata, e_rdata);
        checkOutput({tag, "_err"}, {31'b0, o.err}, {31'b0, e_err});
        checkOutput({tag, "_latency"}, o.lat, e_lat);
        checkOutput({tag, "_we_cycles"}, o.we_n, e_we);
        checkOutput({tag, "_re_cycles"}, o.re_n, e_re);
        checkOutput({tag, "_protocol"}, o.proto_bad, 0);
        checkOutput({tag, "_release"}, {30'b0, o.valid_after, o.ready_after}, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t        vecs [9];
        obs_t        o;
        logic [31:0] e_rdata;
        logic        e_err;
        int          e_lat, e_we, e_re;
        int          n_rdy, n_rsp, n_bad, n_hi;

        vecs[0] = '{1'b0, 32'h08, 32'h0,          4'h0, 0, 0, 32'h0020_0010, 1'b0, 3, 0, 1};
        vecs[1] = '{1'b1, 32'h00, 32'h1234_5678,  4'hF, 0, 0, 32'h0,         1'b0, 3, 1, 0};
        vecs[2] = '{1'b0, 32'h00, 32'h0,          4'h0, 0, 0, 32'h1234_5678, 1'b0, 3, 0, 1};
        vecs[3] = '{1'b0, 32'h20, 32'h0,          4'h0, 3, 0, 32'hCAFE_0020, 1'b0, 6, 0, 4};
        vecs[4] = '{1'b0, 32'h06, 32'h0,          4'h0, 0, 5, 32'h0,         1'b1, 1, 0, 0};
        vecs[5] = '{1'b1, 32'h04, 32'hAABB_CCDD,  4'h5, 1, 0, 32'h0,         1'b0, 4, 2, 0};
        vecs[6] = '{1'b0, 32'h04, 32'h0,          4'h0, 2, 1, 32'h00BB_00DD, 1'b0, 5, 0, 3};
        vecs[7] = '{1'b1, 32'h01, 32'hFFFF_FFFF,  4'hF, 0, 0, 32'h0,         1'b1, 1, 0, 0};
        vecs[8] = '{1'b0, 32'h00, 32'h0,          4'h0, 0, 2, 32'h1234_5678, 1'b0, 3, 0, 1};

        rst_b = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'h0;
        cmd_wdata = 32'h0; cmd_wstrb = 4'h0; rsp_ready = 1'b0;
        model_init();
        #3;
        checkOutput("reset_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        checkOutput("reset_rsp_valid_err", {30'b0, rsp_valid, rsp_err}, 32'd0);
        checkOutput("reset_rsp_rdata", rsp_rdata, 32'h0);
        checkOutput("reset_we_re", {30'b0, bus.WE, bus.RE}, 32'd0);
        checkOutput("reset_addr", bus.ADDR, 32'h0);
        checkOutput("reset_data_wr", bus.DATA_WR, 32'h0);
        checkOutput("reset_wstrb", {28'b0, bus.WSTRB}, 32'd0);
        repeat (2) @(negedge clk);
        rst_b = 1'b1;

        $display("[TB] directed vector table");
        for (int i = 0; i < 9; i++) begin
            model_predict(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, vecs[i].wt,
                          e_rdata, e_err, e_lat, e_we, e_re);
            applyStimulus(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb,
                          vecs[i].wt, vecs[i].hold, o);
            checkTxn($sformatf("vec%0d", i), vecs[i].exp_rdata, vecs[i].exp_err,
                     vecs[i].exp_lat, vecs[i].exp_we, vecs[i].exp_re, o);
        end

        $display("[TB] randomized transactions against reference model");
        for (int t = 0; t < 40; t++) begin
            logic        wr;
            logic [31:0] a, wd;
            logic [3:0]  ws;
            int          wt, hold;
            wr   = 1'($urandom_range(0, 1));
            a    = 32'($urandom_range(0, 15)) * 4;
            if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
            wd   = $urandom;
            ws   = 4'($urandom_range(1, 15));
            wt   = int'($urandom_range(0, 3));
            hold = int'($urandom_range(0, 2));
            model_predict(wr, a, wd, ws, wt, e_rdata, e_err, e_lat, e_we, e_re);
            applyStimulus(wr, a, wd, ws, wt, hold, o);
            checkTxn($sformatf("rand%0d", t), e_rdata, e_err, e_lat, e_we, e_re, o);
        end

        $display("[TB] back-to-back throughput");
        resp_wait = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h8; rsp_ready = 1'b1;
        n_rdy = 0; n_rsp = 0; n_bad = 0;
        for (int k = 0; k < 16; k++) begin
            if (k > 0) @(negedge clk);
            if (cmd_ready) n_rdy++;
            if (rsp_valid) begin
                n_rsp++;
                if (rsp_rdata != model_mem[2] || rsp_err) n_bad++;
            end
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        rsp_ready = 1'b0;
        checkOutput("b2b_accepts_16_cycles", n_rdy, 4);
        checkOutput("b2b_responses_16_cycles", n_rsp, 4);
        checkOutput("b2b_response_data", n_bad, 0);

        stuck = 1'b1;
`ifdef REG_BUS_INITIATOR_TIMEOUT_EN
        $display("[TB] access timeout");
        applyStimulus(1'b0, 32'h10, 32'h0, 4'h0, 0, 0, o);
        checkTxn("timeout", 32'h0, 1'b1, TO + 2, 0, TO, o);
        start_cmd(1'b0, 32'h10, 32'h0, 4'h0);
        repeat (5) @(negedge clk);
`else
        $display("[TB] stuck responder without timeout");
        start_cmd(1'b0, 32'h10, 32'h0, 4'h0);
        @(negedge clk);
        n_hi = 0;
        repeat (100) begin
            @(negedge clk);
            if (bus.RE && !bus.WE && !rsp_valid) n_hi++;
        end
        checkOutput("stuck_re_held_100", n_hi, 100);
`endif

        $display("[TB] reset during ACCESS");
        checkOutput("pre_reset_re_high", {31'b0, bus.RE}, 32'd1);
        #2;
        rst_b = 1'b0;
        #1;
        checkOutput("async_reset_we_re", {30'b0, bus.WE, bus.RE}, 32'd0);
        checkOutput("async_reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        stuck = 1'b0;
        model_init();
        @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);
        checkOutput("post_reset_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        checkOutput("post_reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        model_predict(1'b0, 32'h8, 32'h0, 4'h0, 0, e_rdata, e_err, e_lat, e_we, e_re);
        applyStimulus(1'b0, 32'h8, 32'h0, 4'h0, 0, 0, o);
        checkTxn("post_reset_read", e_rdata, e_err, e_lat, e_we, e_re, o);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
